// File: rtl/mbist_pkg.sv
// mbist_pkg: fault-type encodings, access-port select constants and width helper
package mbist_pkg;
  typedef enum logic [2:0] {
    FT_NONE   = 3'd0,
    FT_SA0    = 3'd1,
    FT_SA1    = 3'd2,
    FT_TF_UP  = 3'd3,
    FT_CF_INV = 3'd4
  } fault_type_e;
  localparam logic PORT_FUNC = 1'b0;
  localparam logic PORT_BIST = 1'b1;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_bank.sv
// sram_bank: one word-addressed bank with write-side transition and coupling faults
module sram_bank
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BIT_W      = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  fault_en,
  input  logic [2:0]            fault_type,
  input  logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic [ADDR_WIDTH-1:0] fault_target,
  input  logic [BIT_W-1:0]      fault_bit
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] mask, wval;
  logic                  hit, tf, cf;
  assign rdata = mem[raddr];
  // Fault decode: transition-up keeps a stored 0 from rising, coupling flips the target cell
  always_comb begin
    mask = DATA_WIDTH'(1) << fault_bit;
    hit  = fault_en && waddr == fault_addr;
    tf   = hit && fault_type == FT_TF_UP;
    cf   = hit && fault_type == FT_CF_INV && fault_target != fault_addr;
    wval = tf ? wdata & ~(mask & ~mem[waddr]) : wdata;
  end
  // Array write; contents are deliberately never reset
  always_ff @(posedge clk)
    if (we) begin
      mem[waddr] <= wval;
      if (cf) mem[fault_target] <= mem[fault_target] ^ mask;
    end
endmodule

// File: rtl/sram_bank_wrapper.sv
// sram_bank_wrapper: multi-bank SRAM with functional/BIST port mux, read fault masking and read pipeline
module sram_bank_wrapper
  import mbist_pkg::*;
#(
  parameter int NUM_BANKS    = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  localparam int BANK_BITS   = clog2_min1(NUM_BANKS),
  localparam int FA          = BANK_BITS + ADDR_WIDTH,
  localparam int BIT_W       = clog2_min1(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bist_mode,
  input  logic                  func_cs,
  input  logic                  func_we,
  input  logic                  func_re,
  input  logic [FA-1:0]         func_addr,
  input  logic [DATA_WIDTH-1:0] func_wdata,
  input  logic                  bist_cs,
  input  logic                  bist_we,
  input  logic                  bist_re,
  input  logic [FA-1:0]         bist_addr,
  input  logic [DATA_WIDTH-1:0] bist_wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  access_err,
  input  logic                  fault_enable,
  input  logic [BANK_BITS-1:0]  fault_bank,
  input  logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic [ADDR_WIDTH-1:0] fault_target,
  input  logic [2:0]            fault_type,
  input  logic [BIT_W-1:0]      fault_bit
);
  logic                  cs, we, re, acc, wr, rd, in_range, hit;
  logic [FA-1:0]         addr;
  logic [DATA_WIDTH-1:0] wdata, raw, mask, rd_word;
  logic [BANK_BITS-1:0]  bank;
  logic [ADDR_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] bank_q [2**BANK_BITS];
  logic [READ_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] dat [READ_LATENCY];
  // Port select, access decode and stuck-at masking of read data
  always_comb begin
    cs       = bist_mode == PORT_BIST ? bist_cs    : func_cs;
    we       = bist_mode == PORT_BIST ? bist_we    : func_we;
    re       = bist_mode == PORT_BIST ? bist_re    : func_re;
    addr     = bist_mode == PORT_BIST ? bist_addr  : func_addr;
    wdata    = bist_mode == PORT_BIST ? bist_wdata : func_wdata;
    acc      = cs && (we || re);
    wr       = acc && we;
    rd       = acc && re && !we;
    bank     = addr[FA-1:ADDR_WIDTH];
    word     = addr[ADDR_WIDTH-1:0];
    in_range = 32'(bank) < NUM_BANKS;
    raw      = bank_q[bank];
    mask     = DATA_WIDTH'(1) << fault_bit;
    hit      = fault_enable && in_range && bank == fault_bank && word == fault_addr;
    rd_word  = !in_range ? '0 :
               hit && fault_type == FT_SA0 ? raw & ~mask :
               hit && fault_type == FT_SA1 ? raw | mask : raw;
  end
  for (genvar b = 0; b < 2**BANK_BITS; b++) begin : g_bank
    if (b < NUM_BANKS) begin : g_mem
      sram_bank #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .BIT_W     (BIT_W)
      ) u_bank (
        .clk         (clk),
        .we          (wr && bank == BANK_BITS'(b)),
        .waddr       (word),
        .wdata       (wdata),
        .raddr       (word),
        .rdata       (bank_q[b]),
        .fault_en    (fault_enable && fault_bank == BANK_BITS'(b)),
        .fault_type  (fault_type),
        .fault_addr  (fault_addr),
        .fault_target(fault_target),
        .fault_bit   (fault_bit)
      );
    end else begin : g_none
      assign bank_q[b] = '0;
    end
  end
  // Read data captured at the accepting edge then shifted; error flag registered one cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld        <= '0;
      access_err <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0]     <= rd;
      dat[0]     <= rd_word;
      access_err <= acc && !in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  assign rvalid = vld[READ_LATENCY-1];
  assign rdata  = dat[READ_LATENCY-1];
endmodule

// File: tb/tb_sram_bank_wrapper.sv
// tb_sram_bank_wrapper: checks a 4-bank and a 3-bank wrapper against a behavioural memory model
module tb_sram_bank_wrapper;
  import mbist_pkg::*;
  localparam int RL = 2;
  logic clk = 0, reset_n = 0, bist_mode = 0;
  logic func_cs = 0, func_we = 0, func_re = 0, bist_cs = 0, bist_we = 0, bist_re = 0;
  logic [9:0] func_addr = 0, bist_addr = 0;
  logic [31:0] func_wdata = 0, bist_wdata = 0;
  logic fault_enable = 0;
  logic [1:0] fault_bank = 0;
  logic [7:0] fault_addr = 0, fault_target = 0;
  logic [2:0] fault_type = 0;
  logic [4:0] fault_bit = 0;
  logic [31:0] rdata4, rdata3;
  logic rvalid4, rvalid3, err4, err3;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] mem [2][4][256];
  int nb [2] = '{4, 3};
  typedef struct {int dut; int due; logic [31:0] d;} rd_t;
  rd_t q [$];
  logic exp_v [2], exp_e [2];
  logic [31:0] exp_d [2];

  always #5 clk = ~clk;

  sram_bank_wrapper #(.NUM_BANKS(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(RL)) dut4 (
    .clk(clk), .reset_n(reset_n), .bist_mode(bist_mode),
    .func_cs(func_cs), .func_we(func_we), .func_re(func_re), .func_addr(func_addr), .func_wdata(func_wdata),
    .bist_cs(bist_cs), .bist_we(bist_we), .bist_re(bist_re), .bist_addr(bist_addr), .bist_wdata(bist_wdata),
    .rdata(rdata4), .rvalid(rvalid4), .access_err(err4),
    .fault_enable(fault_enable), .fault_bank(fault_bank), .fault_addr(fault_addr),
    .fault_target(fault_target), .fault_type(fault_type), .fault_bit(fault_bit));

  sram_bank_wrapper #(.NUM_BANKS(3), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(RL)) dut3 (
    .clk(clk), .reset_n(reset_n), .bist_mode(bist_mode),
    .func_cs(func_cs), .func_we(func_we), .func_re(func_re), .func_addr(func_addr), .func_wdata(func_wdata),
    .bist_cs(bist_cs), .bist_we(bist_we), .bist_re(bist_re), .bist_addr(bist_addr), .bist_wdata(bist_wdata),
    .rdata(rdata3), .rvalid(rvalid3), .access_err(err3),
    .fault_enable(fault_enable), .fault_bank(fault_bank), .fault_addr(fault_addr),
    .fault_target(fault_target), .fault_type(fault_type), .fault_bit(fault_bit));

  function automatic bit fhit(int b, int w);
    return fault_enable && int'(fault_bank) == b && int'(fault_addr) == w;
  endfunction

  function automatic void model_write(int d, int b, int w, logic [31:0] wd);
    if (b >= nb[d]) return;
    if (fhit(b, w) && fault_type == FT_TF_UP && !mem[d][b][w][fault_bit]) wd[fault_bit] = 1'b0;
    if (fhit(b, w) && fault_type == FT_CF_INV && int'(fault_target) != w)
      mem[d][b][fault_target][fault_bit] = ~mem[d][b][fault_target][fault_bit];
    mem[d][b][w] = wd;
  endfunction

  function automatic logic [31:0] model_read(int d, int b, int w);
    logic [31:0] v;
    if (b >= nb[d]) return 32'h0;
    v = mem[d][b][w];
    if (fhit(b, w) && fault_type == FT_SA0) v[fault_bit] = 1'b0;
    if (fhit(b, w) && fault_type == FT_SA1) v[fault_bit] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    logic c, w, r;
    logic [9:0] a;
    logic [31:0] wd;
    @(posedge clk);
    cyc++;
    exp_e[0] = 0; exp_e[1] = 0;
    if (reset_n) begin
      c  = bist_mode ? bist_cs : func_cs;
      w  = bist_mode ? bist_we : func_we;
      r  = bist_mode ? bist_re : func_re;
      a  = bist_mode ? bist_addr : func_addr;
      wd = bist_mode ? bist_wdata : func_wdata;
      if (c && (w || r))
        for (int d = 0; d < 2; d++) begin
          exp_e[d] = int'(a[9:8]) >= nb[d];
          if (w) model_write(d, int'(a[9:8]), int'(a[7:0]), wd);
          else q.push_back('{d, cyc + RL - 1, model_read(d, int'(a[9:8]), int'(a[7:0]))});
        end
    end
    #1;
    exp_v[0] = 0; exp_v[1] = 0; exp_d[0] = 0; exp_d[1] = 0;
    while (q.size() > 0 && q[0].due == cyc) begin
      exp_v[q[0].dut] = 1;
      exp_d[q[0].dut] = q[0].d;
      void'(q.pop_front());
    end
  endtask

  task automatic step(input logic bm, input logic c, input logic w, input logic r,
                      input logic [9:0] a, input logic [31:0] wd);
    bist_mode = bm;
    if (bm) begin
      bist_cs = c; bist_we = w; bist_re = r; bist_addr = a; bist_wdata = wd;
      func_cs = 1'($urandom); func_we = 1'($urandom); func_re = 1'($urandom);
      func_addr = 10'($urandom); func_wdata = $urandom;
    end else begin
      func_cs = c; func_we = w; func_re = r; func_addr = a; func_wdata = wd;
      bist_cs = 1'($urandom); bist_we = 1'($urandom); bist_re = 1'($urandom);
      bist_addr = 10'($urandom); bist_wdata = $urandom;
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (rvalid4 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid4: got %b exp 0", rvalid4); end
    n_chk++; if (rvalid3 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid3: got %b exp 0", rvalid3); end
    n_chk++; if (rdata4 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata4: got %h exp 0", rdata4); end
    n_chk++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL reset_err3: got %b exp 0", err3); end
    @(negedge clk) reset_n = 1;
  endtask

  task automatic fill();
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 256; w++)
        step(1'($urandom), 1, 1, 0, {2'(b), 8'(w)}, $urandom);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    step(0, 1, 1, 0, 10'h110, 32'hA5A5_0001);
    step(0, 1, 0, 1, 10'h110, 0);
    n_chk++; if (rvalid4 !== 1'b0) begin n_fail++; $display("FAIL basic_early: rvalid4 got %b exp 0", rvalid4); end
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rvalid4 !== 1'b1) begin n_fail++; $display("FAIL basic_valid: rvalid4 got %b exp 1", rvalid4); end
    n_chk++; if (rdata4 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL basic_data: rdata4 got %h exp a5a50001", rdata4); end
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rvalid4 !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: rvalid4 got %b exp 0", rvalid4); end
    step(0, 1, 1, 1, 10'h110, 32'h1234_5678);
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rvalid4 !== 1'b0) begin n_fail++; $display("FAIL we_re_norvalid: rvalid4 got %b exp 0", rvalid4); end
    step(0, 1, 0, 1, 10'h110, 0);
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rdata4 !== 32'h1234_5678) begin n_fail++; $display("FAIL we_re_write: rdata4 got %h exp 12345678", rdata4); end
  endtask

  task automatic test_sa1();
    fault_enable = 1; fault_bank = 2; fault_addr = 8'h05; fault_bit = 3; fault_type = FT_SA1;
    step(0, 1, 1, 0, 10'h205, 32'h0);
    step(0, 1, 0, 1, 10'h205, 0);
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rdata4 !== 32'h8) begin n_fail++; $display("FAIL sa1_on: rdata4 got %h exp 00000008", rdata4); end
    n_chk++; if (rdata3 !== 32'h8) begin n_fail++; $display("FAIL sa1_on3: rdata3 got %h exp 00000008", rdata3); end
    fault_enable = 0;
    step(1, 1, 0, 1, 10'h205, 0);
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rdata4 !== 32'h0) begin n_fail++; $display("FAIL sa1_off: rdata4 got %h exp 0", rdata4); end
  endtask

  task automatic test_coupling();
    fault_enable = 1; fault_bank = 0; fault_addr = 8'h01; fault_target = 8'h02; fault_bit = 0; fault_type = FT_CF_INV;
    step(0, 1, 1, 0, 10'h002, 32'h0);
    step(0, 1, 1, 0, 10'h001, 32'hFF);
    step(0, 1, 0, 1, 10'h002, 0);
    step(0, 1, 0, 1, 10'h001, 0);
    n_chk++; if (rdata4 !== 32'h1) begin n_fail++; $display("FAIL cf_target: rdata4 got %h exp 00000001", rdata4); end
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rdata4 !== 32'hFF) begin n_fail++; $display("FAIL cf_aggr: rdata4 got %h exp 000000ff", rdata4); end
    fault_enable = 0;
  endtask

  task automatic test_tf_up();
    step(0, 1, 1, 0, 10'h107, 32'h10);
    fault_enable = 1; fault_bank = 1; fault_addr = 8'h07; fault_bit = 4; fault_type = FT_TF_UP;
    step(0, 1, 1, 0, 10'h107, 32'h0);
    step(0, 1, 0, 1, 10'h107, 0);
    step(0, 1, 1, 0, 10'h107, 32'hFF);
    n_chk++; if (rdata4 !== 32'h0) begin n_fail++; $display("FAIL tf_fall: rdata4 got %h exp 0", rdata4); end
    step(0, 1, 0, 1, 10'h107, 0);
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rdata4 !== 32'hEF) begin n_fail++; $display("FAIL tf_rise: rdata4 got %h exp 000000ef", rdata4); end
    fault_enable = 0;
  endtask

  task automatic test_oob();
    logic [31:0] e4, keep [3];
    e4 = mem[0][3][8'h20];
    for (int b = 0; b < 3; b++) keep[b] = mem[1][b][8'h20];
    step(0, 1, 0, 1, 10'h320, 0);
    n_chk++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL oob_err: err3 got %b exp 1", err3); end
    n_chk++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL oob_err4: err4 got %b exp 0", err4); end
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL oob_err_pulse: err3 got %b exp 0", err3); end
    n_chk++; if (rvalid3 !== 1'b1 || rdata3 !== 32'h0) begin n_fail++; $display("FAIL oob_read: rvalid3 %b rdata3 %h exp 1 0", rvalid3, rdata3); end
    n_chk++; if (rdata4 !== e4) begin n_fail++; $display("FAIL oob_bank3_4: rdata4 got %h exp %h", rdata4, e4); end
    step(1, 1, 1, 0, 10'h320, 32'h1234_5678);
    n_chk++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL oob_werr: err3 got %b exp 1", err3); end
    for (int b = 0; b < 4; b++) begin
      if (b < 3) step(0, 1, 0, 1, {2'(b), 8'h20}, 0); else step(0, 0, 0, 0, 0, 0);
      if (b > 0) begin
        n_chk++; if (rdata3 !== keep[b-1]) begin n_fail++; $display("FAIL oob_alias%0d: rdata3 got %h exp %h", b - 1, rdata3, keep[b-1]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e [4];
    for (int i = 0; i < 4; i++) e[i] = mem[0][i][8'h40 + i];
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(1'(i), 1, 0, 1, {2'(i), 8'(8'h40 + i)}, 0); else step(0, 0, 0, 0, 0, 0);
      if (i > 0) begin
        n_chk++; if (rvalid4 !== 1'b1 || rdata4 !== e[i-1]) begin n_fail++; $display("FAIL b2b%0d: rvalid4 %b rdata4 %h exp 1 %h", i - 1, rvalid4, rdata4, e[i-1]); end
      end
    end
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rvalid4 !== 1'b0) begin n_fail++; $display("FAIL b2b_end: rvalid4 got %b exp 0", rvalid4); end
  endtask

  task automatic test_reset_inflight();
    step(0, 1, 1, 0, 10'h033, 32'hDEAD_0033);
    step(0, 1, 0, 1, 10'h033, 0);
    #2 reset_n = 0;
    #1;
    q.delete();
    n_chk++; if (rvalid4 !== 1'b0 || rdata4 !== 32'h0) begin n_fail++; $display("FAIL rst_flight: rvalid4 %b rdata4 %h exp 0 0", rvalid4, rdata4); end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rvalid4 !== 1'b0 || rvalid3 !== 1'b0) begin n_fail++; $display("FAIL rst_hold: rvalid4 %b rvalid3 %b exp 0", rvalid4, rvalid3); end
    @(negedge clk) reset_n = 1;
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rvalid4 !== 1'b0) begin n_fail++; $display("FAIL rst_after: rvalid4 got %b exp 0", rvalid4); end
    step(0, 1, 0, 1, 10'h033, 0);
    step(0, 0, 0, 0, 0, 0);
    n_chk++; if (rvalid4 !== 1'b1 || rdata4 !== 32'hDEAD_0033) begin n_fail++; $display("FAIL rst_keep: rvalid4 %b rdata4 %h exp 1 dead0033", rvalid4, rdata4); end
  endtask

  task automatic test_random();
    logic gv [2], ge [2];
    logic [31:0] gd [2];
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        fault_enable = 1'($urandom); fault_bank = 2'($urandom); fault_addr = 8'($urandom_range(0, 7));
        fault_target = 8'($urandom_range(0, 7)); fault_type = 3'($urandom); fault_bit = 5'($urandom);
      end
      step(1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           {2'($urandom), 8'($urandom_range(0, 7))}, $urandom);
      gv[0] = rvalid4; gv[1] = rvalid3; gd[0] = rdata4; gd[1] = rdata3; ge[0] = err4; ge[1] = err3;
      for (int d = 0; d < 2; d++) begin
        n_chk++; if (gv[d] !== exp_v[d]) begin n_fail++; $display("FAIL rnd_rvalid dut%0d cyc %0d: got %b exp %b", d, cyc, gv[d], exp_v[d]); end
        n_chk++; if (ge[d] !== exp_e[d]) begin n_fail++; $display("FAIL rnd_err dut%0d cyc %0d: got %b exp %b", d, cyc, ge[d], exp_e[d]); end
        if (exp_v[d]) begin
          n_chk++; if (gd[d] !== exp_d[d]) begin n_fail++; $display("FAIL rnd_rdata dut%0d cyc %0d: got %h exp %h", d, cyc, gd[d], exp_d[d]); end
        end
      end
    end
    fault_enable = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    fill();
    test_basic();
    test_sa1();
    test_coupling();
    test_tf_up();
    test_oob();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
